axis_packet_splitter_mc: RTL and testbench
==========================================

# axis_packet_splitter_mc

Multi-channel AXI-Stream packet splitter with a per-operation channel mask, a sticky error path, abort, and per-channel packet counters. Each enabled channel re-frames its input stream into packets of `pckt_size` beats. An operation completes only when every enabled channel has drained its input on a packet boundary. The block sits between the DMA read streams and the KAN compute lanes, and replaces per-channel splitter instances plus external aggregation glue.

## Interface
- `CHANNELS`, 4: number of independent AXI-Stream lanes (1..32).
- `DATA_WIDTH`, 16: tdata width per lane.
- `KEEP_WIDTH`, (DATA_WIDTH+7)/8: tkeep width per lane; passed through unchanged.
- `USER_WIDTH`, 1: tuser width per lane; passed through unchanged.
- `PCKT_WIDTH`, 16: width of `pckt_size` and of the beat counter.
- `CNT_WIDTH`, 16: width of each per-channel output-packet counter; saturates.
- `RAISE_NON_DIVISIBLE`, 1: input tlast off a packet boundary raises error; 0 = emit a short final packet.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; deassertion synchronous to `clk`.
- `operation_start`  in  1  single-cycle start strobe; honoured only in IDLE.
- `abort`  in  1  forces ERROR from RUN; ignored elsewhere.
- `pckt_size`  in  PCKT_WIDTH  beats per output packet; sampled on start.
- `chn_mask`  in  CHANNELS  lanes taking part in the operation; sampled on start.
- `external_error`  in  1  forces ERROR from RUN.
- `operation_busy`  out  1  high in RUN.
- `operation_complete`  out  1  one-cycle pulse on RUN→IDLE success.
- `operation_error`  out  1  high in ERROR.
- `error_cause`  out  3  {zero_size, non_divisible, external_or_abort}; sticky in ERROR.
- `chn_done`  out  CHANNELS  lane has finished its input (masked-out lanes read 1 during RUN).
- `pckt_count`  out  CHANNELS*CNT_WIDTH  output packets emitted per lane this operation.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  in/out  CHANNELS× the widths above; slave streams, lane i at slice i.
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  out/in  CHANNELS× the widths above; master streams.

## Operation
- FSM has three states: IDLE, RUN, ERROR.
- IDLE + `operation_start`: latch `pckt_size` and `chn_mask`, clear the beat counters, `pckt_count` and `chn_done`.
  - `pckt_size==0` or `chn_mask==0`: go to ERROR, zero_size=1.
  - Otherwise go to RUN.
- Datapath is combinational per lane `i`:
  - `m_tvalid[i] = s_tvalid[i] & run & mask[i] & ~chn_done[i]`
  - `s_tready[i] = m_tready[i] & run & mask[i] & ~chn_done[i]`
  - tdata/tkeep/tuser pass straight through. No buffering.
- Beat counter per lane:
  - Increments on each handshake.
  - `m_tlast[i]` is asserted when `beat_cnt==pckt_size-1` or when `s_tlast[i]` is high.
  - The counter wraps to 0 on an output tlast handshake.
  - `pckt_count[i]` increments on that same handshake, saturating at all-ones.
- Handshake with `s_tlast` high:
  - Boundary beat (`beat_cnt==pckt_size-1`): `chn_done[i]` is set and the lane stops accepting data.
  - Off boundary with RAISE_NON_DIVISIBLE=1: go to ERROR, non_divisible=1. The beat itself is still forwarded.
  - Off boundary with RAISE_NON_DIVISIBLE=0: the short packet closes and `chn_done[i]` is set.
- RUN→IDLE when all of `chn_done | ~mask` are 1. `operation_complete` pulses in that IDLE's first cycle.
- In RUN, `external_error` or `abort` sends the FSM to ERROR with external_or_abort=1. Same-cycle priority: error/abort > non_divisible > completion.
- ERROR:
  - All tready and tvalid are 0.
  - Outputs stay sticky until `operation_start`, which restarts exactly as from IDLE (same checks).
  - `pckt_count` and `chn_done` hold their values for readout.
- `operation_start` during RUN is ignored.

## Timing
- Reset values:
  - FSM in IDLE; `operation_busy`, `operation_complete`, `operation_error` = 0; `error_cause` = 0.
  - `chn_done`, `pckt_count` and all beat counters = 0.
  - All m_tvalid/s_tready = 0. m_tlast is combinational; it is a don't-care while m_tvalid=0.
- Reset asserted mid-operation: immediate return to the reset values, with no pending handshake completed.
- Start strobe at cycle N: `operation_busy`=1 and the first handshake is possible at N+1. Datapath latency is 0 cycles.
- Final handshake at cycle M: `operation_busy`=0 and `operation_complete`=1 at M+1 only.
- Error condition at cycle M: `operation_error`=1 from M+1. tready/tvalid drop at M+1.
- The lane's `chn_done` bit is registered; the lane is blocked from the cycle after its final beat.
- Masked-out lanes never assert tready or tvalid.

## Test plan
- CHANNELS=4, pckt_size=4, mask=4'b1111; each lane gets 12 beats with tlast on beat 12, and m_tready is randomly throttled.
  - Each lane emits tlast on beats 4/8/12.
  - `pckt_count`=3 per lane.
  - One `operation_complete` pulse, one cycle after the last lane's final beat.
- mask=4'b0101, pckt_size=3, 6 beats on lanes 0 and 2.
  - Lanes 1 and 3 never assert tready.
  - Completion after both active lanes finish; `chn_done` reads 4'b1111.
- RAISE_NON_DIVISIBLE=1, pckt_size=4, tlast on beat 6 of lane 1.
  - Beat 6 is forwarded with m_tlast=1.
  - `operation_error`=1 next cycle, `error_cause`=3'b010, all tready=0.
- RAISE_NON_DIVISIBLE=0, same stimulus.
  - Packets of 4 and 2 beats; `pckt_count[1]`=2; normal completion.
- pckt_size=0 start → ERROR next cycle with `error_cause`=3'b100. Then a start with pckt_size=2 enters RUN.
- `abort` asserted mid-packet, then `rst` pulled low mid-RUN.
  - Abort: ERROR with cause 3'b001.
  - Reset: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/axis_packet_splitter_mc_if.sv
// rtl/axis_packet_splitter_mc_if.sv - bundled multi-lane AXI-Stream signals
interface axis_packet_splitter_mc_if #(
   parameter int CHANNELS   = 4,
   parameter int DATA_WIDTH = 16,
   parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
   parameter int USER_WIDTH = 1
);
   logic [CHANNELS*DATA_WIDTH-1:0] tdata;
   logic [CHANNELS*KEEP_WIDTH-1:0] tkeep;
   logic [CHANNELS-1:0]            tvalid;
   logic [CHANNELS-1:0]            tready;
   logic [CHANNELS-1:0]            tlast;
   logic [CHANNELS*USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_packet_splitter_mc.sv
// rtl/axis_packet_splitter_mc.sv - multi-lane AXI-Stream re-framer with mask, error path and packet counters
module axis_packet_splitter_mc #(
   parameter int CHANNELS            = 4,
   parameter int DATA_WIDTH          = 16,
   parameter int KEEP_WIDTH          = (DATA_WIDTH + 7) / 8,
   parameter int USER_WIDTH          = 1,
   parameter int PCKT_WIDTH          = 16,
   parameter int CNT_WIDTH           = 16,
   parameter bit RAISE_NON_DIVISIBLE = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          operation_start,
   input  logic                          abort,
   input  logic [PCKT_WIDTH-1:0]         pckt_size,
   input  logic [CHANNELS-1:0]           chn_mask,
   input  logic                          external_error,
   output logic                          operation_busy,
   output logic                          operation_complete,
   output logic                          operation_error,
   output logic [2:0]                    error_cause,
   output logic [CHANNELS-1:0]           chn_done,
   output logic [CHANNELS*CNT_WIDTH-1:0] pckt_count,
   axis_packet_splitter_mc_if.slave      s_axis,
   axis_packet_splitter_mc_if.master     m_axis
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERROR} state_t;

   localparam logic [PCKT_WIDTH-1:0] BEAT_ONE = PCKT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  PKT_ONE  = CNT_WIDTH'(1);

   state_t                state, state_nxt;
   logic [PCKT_WIDTH-1:0] size_q;
   logic [CHANNELS-1:0]   mask_q;
   logic [CHANNELS-1:0]   done_q;
   logic [PCKT_WIDTH-1:0] beat_cnt [CHANNELS];
   logic [CNT_WIDTH-1:0]  pkt_cnt  [CHANNELS];
   logic [2:0]            cause_q, cause_nxt;
   logic                  complete_q, complete_nxt;
   logic                  load;

   logic                  run;
   logic [CHANNELS-1:0]   active, hs, at_bound, last_hs, off_bound_last, done_set, done_nxt;

   assign run = (state == S_RUN);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      assign active[i]   = run & mask_q[i] & ~done_q[i];
      assign m_axis.tvalid[i] = s_axis.tvalid[i] & active[i];
      assign s_axis.tready[i] = m_axis.tready[i] & active[i];
      assign m_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH] = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign m_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      assign m_axis.tuser[i*USER_WIDTH +: USER_WIDTH] = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];

      assign at_bound[i]       = (beat_cnt[i] == size_q - BEAT_ONE);
      assign m_axis.tlast[i]   = at_bound[i] | s_axis.tlast[i];
      assign hs[i]             = s_axis.tvalid[i] & m_axis.tready[i] & active[i];
      assign last_hs[i]        = hs[i] & (at_bound[i] | s_axis.tlast[i]);
      assign off_bound_last[i] = hs[i] & s_axis.tlast[i] & ~at_bound[i];
      // A short final packet still finishes the lane when non-divisible input is tolerated
      assign done_set[i]       = hs[i] & s_axis.tlast[i] & (at_bound[i] | ~RAISE_NON_DIVISIBLE);

      assign pckt_count[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[i];
   end

   assign done_nxt = done_q | done_set;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      load         = 1'b0;
      complete_nxt = 1'b0;
      cause_nxt    = cause_q;
      case (state)
         S_IDLE, S_ERROR: begin
            if (operation_start) begin
               load      = 1'b1;
               cause_nxt = 3'b000;
               if ((pckt_size == '0) || (chn_mask == '0)) begin
                  state_nxt = S_ERROR;
                  cause_nxt = 3'b100;
               end else begin
                  state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (external_error || abort) begin
               state_nxt = S_ERROR;
               cause_nxt = 3'b001;
            end else if (RAISE_NON_DIVISIBLE && (|off_bound_last)) begin
               state_nxt = S_ERROR;
               cause_nxt = 3'b010;
            end else if (&done_nxt) begin
               state_nxt    = S_IDLE;
               complete_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         size_q     <= '0;
         mask_q     <= '0;
         done_q     <= '0;
         cause_q    <= '0;
         complete_q <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            beat_cnt[i] <= '0;
            pkt_cnt[i]  <= '0;
         end
      end else begin
         complete_q <= complete_nxt;
         cause_q    <= cause_nxt;
         if (load) begin
            size_q <= pckt_size;
            mask_q <= chn_mask;
            // Lanes outside the mask count as finished for the whole operation
            done_q <= ~chn_mask;
            for (int i = 0; i < CHANNELS; i++) begin
               beat_cnt[i] <= '0;
               pkt_cnt[i]  <= '0;
            end
         end else begin
            done_q <= done_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
               if (hs[i]) begin
                  beat_cnt[i] <= last_hs[i] ? '0 : beat_cnt[i] + BEAT_ONE;
                  if (last_hs[i] && (pkt_cnt[i] != '1)) pkt_cnt[i] <= pkt_cnt[i] + PKT_ONE;
               end
            end
         end
      end
   end

   assign operation_busy     = run;
   assign operation_complete = complete_q;
   assign operation_error    = (state == S_ERROR);
   assign error_cause        = cause_q;
   assign chn_done           = done_q;
endmodule

// File: tb/tb_axis_packet_splitter_mc.sv
// tb/tb_axis_packet_splitter_mc.sv - randomized self-checking bench for axis_packet_splitter_mc
module tb_axis_packet_splitter_mc;
   localparam int CH = 4;
   localparam int DW = 16;
   localparam int KW = 2;
   localparam int UW = 1;
   localparam int PW = 16;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic operation_start = 1'b0;
   logic abort = 1'b0;
   logic external_error = 1'b0;
   logic [PW-1:0] pckt_size = '0;
   logic [CH-1:0] chn_mask = '0;

   logic [CH*DW-1:0] s_tdata = '0;
   logic [CH*KW-1:0] s_tkeep = '0;
   logic [CH-1:0]    s_tvalid = '0;
   logic [CH-1:0]    s_tlast = '0;
   logic [CH*UW-1:0] s_tuser = '0;
   logic [CH-1:0]    m_tready = '0;

   logic          busy_a, complete_a, error_a, busy_b, complete_b, error_b;
   logic [2:0]    cause_a, cause_b;
   logic [CH-1:0] done_a, done_b;
   logic [CH*CW-1:0] count_a, count_b;

   int checks = 0;
   int passes = 0;

   axis_packet_splitter_mc_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_a ();
   axis_packet_splitter_mc_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_a ();
   axis_packet_splitter_mc_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_b ();
   axis_packet_splitter_mc_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_b ();

   assign s_a.tdata = s_tdata;   assign s_b.tdata = s_tdata;
   assign s_a.tkeep = s_tkeep;   assign s_b.tkeep = s_tkeep;
   assign s_a.tvalid = s_tvalid; assign s_b.tvalid = s_tvalid;
   assign s_a.tlast = s_tlast;   assign s_b.tlast = s_tlast;
   assign s_a.tuser = s_tuser;   assign s_b.tuser = s_tuser;
   assign m_a.tready = m_tready; assign m_b.tready = m_tready;

   axis_packet_splitter_mc #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                             .PCKT_WIDTH(PW), .CNT_WIDTH(CW), .RAISE_NON_DIVISIBLE(1'b1)) dut_a (
      .clk(clk), .rst(rst), .operation_start(operation_start), .abort(abort),
      .pckt_size(pckt_size), .chn_mask(chn_mask), .external_error(external_error),
      .operation_busy(busy_a), .operation_complete(complete_a), .operation_error(error_a),
      .error_cause(cause_a), .chn_done(done_a), .pckt_count(count_a),
      .s_axis(s_a), .m_axis(m_a)
   );

   axis_packet_splitter_mc #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                             .PCKT_WIDTH(PW), .CNT_WIDTH(CW), .RAISE_NON_DIVISIBLE(1'b0)) dut_b (
      .clk(clk), .rst(rst), .operation_start(operation_start), .abort(abort),
      .pckt_size(pckt_size), .chn_mask(chn_mask), .external_error(external_error),
      .operation_busy(busy_b), .operation_complete(complete_b), .operation_error(error_b),
      .error_cause(cause_b), .chn_done(done_b), .pckt_count(count_b),
      .s_axis(s_b), .m_axis(m_b)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      m_tready = '1;
      s_tvalid = '1;
      #1;
      checks++;
      if ({busy_a, complete_a, error_a, cause_a, done_a} !== 10'b0 || count_a !== '0 || s_a.tready !== '0 || m_a.tvalid !== '0)
         $display("FAIL reset_a: status %b%b%b cause %b done %b count %h tready %b tvalid %b, want all zero",
                  busy_a, complete_a, error_a, cause_a, done_a, count_a, s_a.tready, m_a.tvalid);
      else passes++;
      checks++;
      if ({busy_b, complete_b, error_b, cause_b, done_b} !== 10'b0 || count_b !== '0 || s_b.tready !== '0)
         $display("FAIL reset_b: status %b%b%b cause %b done %b count %h tready %b, want all zero",
                  busy_b, complete_b, error_b, cause_b, done_b, count_b, s_b.tready);
      else passes++;
      s_tvalid = '0;
      m_tready = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Drives one operation; lane i receives n_i beats (tlast on the last) and is checked against
   // the framing rule: output tlast on every p-th beat and on the final beat, ceil(n/p) packets.
   task automatic run_op(input logic [CH-1:0] mask, input int p, input int n0, input int n1,
                         input int n2, input int n3, input bit throttle, input string tag);
      int n [CH];
      int ptr [CH];
      int cycles;
      int seed;
      bit all_done;
      bit exp_err;
      bit act, exp_v, exp_r, exp_last;
      logic [DW-1:0] exp_data;
      logic [CH-1:0] exp_done_a;
      logic [CW-1:0] exp_cnt;
      seed = $urandom_range(0, 255);
      n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
      exp_err = 1'b0;
      for (int i = 0; i < CH; i++) begin
         ptr[i] = 0;
         if (!mask[i]) n[i] = 0;
         if (n[i] % p != 0) exp_err = 1'b1;
         exp_done_a[i] = !mask[i] || (n[i] % p == 0);
      end
      @(negedge clk);
      pckt_size = PW'(p);
      chn_mask = mask;
      operation_start = 1'b1;
      @(negedge clk);
      operation_start = 1'b0;
      checks++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1)
         $display("FAIL %s busy_after_start: got %b/%b want 1/1", tag, busy_a, busy_b);
      else passes++;
      cycles = 0;
      all_done = 1'b0;
      while (!all_done && cycles < 2000) begin
         for (int i = 0; i < CH; i++) begin
            s_tvalid[i] = (ptr[i] < n[i]) && (!throttle || $urandom_range(0, 3) != 0);
            s_tdata[i*DW +: DW] = DW'(i * 4096 + ptr[i] * 17 + seed);
            s_tkeep[i*KW +: KW] = KW'(ptr[i]);
            s_tuser[i] = 1'(ptr[i] & 1);
            s_tlast[i] = (ptr[i] == n[i] - 1);
            m_tready[i] = !throttle || $urandom_range(0, 2) != 0;
         end
         #1;
         for (int i = 0; i < CH; i++) begin
            act = mask[i] && (ptr[i] < n[i]);
            exp_v = s_tvalid[i] & act;
            exp_r = m_tready[i] & act;
            checks++;
            if (m_a.tvalid[i] !== exp_v || s_a.tready[i] !== exp_r)
               $display("FAIL %s lane%0d valid_ready: got %b%b want %b%b", tag, i, m_a.tvalid[i], s_a.tready[i], exp_v, exp_r);
            else passes++;
            if (exp_v && m_tready[i]) begin
               exp_last = ((ptr[i] + 1) % p == 0) || (ptr[i] + 1 == n[i]);
               exp_data = DW'(i * 4096 + ptr[i] * 17 + seed);
               checks++;
               if (m_a.tlast[i] !== exp_last || m_a.tdata[i*DW +: DW] !== exp_data ||
                   m_a.tkeep[i*KW +: KW] !== KW'(ptr[i]) || m_a.tuser[i] !== 1'(ptr[i] & 1))
                  $display("FAIL %s lane%0d beat%0d: got last %b data %h want last %b data %h",
                           tag, i, ptr[i] + 1, m_a.tlast[i], m_a.tdata[i*DW +: DW], exp_last, exp_data);
               else passes++;
               ptr[i]++;
            end
         end
         all_done = 1'b1;
         for (int i = 0; i < CH; i++) if (ptr[i] < n[i]) all_done = 1'b0;
         @(negedge clk);
         cycles++;
      end
      if (!all_done) begin
         checks++;
         $display("FAIL %s timeout: %0d cycles without finishing, want completion", tag, cycles);
      end
      s_tvalid = '0;
      s_tlast = '0;
      m_tready = '1;
      #1;
      checks++;
      if (exp_err) begin
         if ({busy_a, complete_a, error_a, cause_a} !== 6'b001_010 || s_a.tready !== '0)
            $display("FAIL %s end_status_a: got bce %b%b%b cause %b tready %b want 001 cause 010 tready 0000",
                     tag, busy_a, complete_a, error_a, cause_a, s_a.tready);
         else passes++;
      end else begin
         if ({busy_a, complete_a, error_a, cause_a} !== 6'b010_000)
            $display("FAIL %s end_status_a: got bce %b%b%b cause %b want 010 cause 000",
                     tag, busy_a, complete_a, error_a, cause_a);
         else passes++;
      end
      checks++;
      if ({busy_b, complete_b, error_b, cause_b} !== 6'b010_000 || done_b !== 4'b1111)
         $display("FAIL %s end_status_b: got bce %b%b%b cause %b done %b want 010 cause 000 done 1111",
                  tag, busy_b, complete_b, error_b, cause_b, done_b);
      else passes++;
      checks++;
      if (done_a !== exp_done_a)
         $display("FAIL %s chn_done_a: got %b want %b", tag, done_a, exp_done_a);
      else passes++;
      for (int i = 0; i < CH; i++) begin
         exp_cnt = CW'((n[i] + p - 1) / p);
         checks++;
         if (count_a[i*CW +: CW] !== exp_cnt || count_b[i*CW +: CW] !== exp_cnt)
            $display("FAIL %s pckt_count lane%0d: got %0d/%0d want %0d", tag, i,
                     count_a[i*CW +: CW], count_b[i*CW +: CW], exp_cnt);
         else passes++;
      end
      @(negedge clk);
      checks++;
      if (complete_a !== 1'b0 || complete_b !== 1'b0)
         $display("FAIL %s complete_pulse_width: got %b/%b want 0/0", tag, complete_a, complete_b);
      else passes++;
      m_tready = '0;
   endtask

   task automatic test_full();
      run_op(4'b1111, 4, 12, 12, 12, 12, 1'b1, "full");
   endtask

   task automatic test_mask();
      run_op(4'b0101, 3, 6, 6, 6, 6, 1'b1, "mask");
   endtask

   task automatic test_non_divisible();
      run_op(4'b0010, 4, 0, 6, 0, 0, 1'b1, "nondiv");
   endtask

   task automatic test_zero_size();
      @(negedge clk);
      pckt_size = '0;
      chn_mask = 4'b1111;
      operation_start = 1'b1;
      @(negedge clk);
      operation_start = 1'b0;
      m_tready = '1;
      s_tvalid = '1;
      #1;
      checks++;
      if ({busy_a, error_a, cause_a} !== 5'b01_100 || {busy_b, error_b, cause_b} !== 5'b01_100 ||
          s_a.tready !== '0 || m_a.tvalid !== '0)
         $display("FAIL zero_size: got be %b%b cause %b tready %b tvalid %b want 01 cause 100 tready 0",
                  busy_a, error_a, cause_a, s_a.tready, m_a.tvalid);
      else passes++;
      s_tvalid = '0;
      @(negedge clk);
      pckt_size = PW'(3);
      chn_mask = '0;
      operation_start = 1'b1;
      @(negedge clk);
      operation_start = 1'b0;
      #1;
      checks++;
      if ({busy_a, error_a, cause_a} !== 5'b01_100)
         $display("FAIL zero_mask: got be %b%b cause %b want 01 cause 100", busy_a, error_a, cause_a);
      else passes++;
      m_tready = '0;
      run_op(4'b0001, 2, 4, 0, 0, 0, 1'b1, "after_zero");
   endtask

   task automatic test_abort_and_reset();
      @(negedge clk);
      pckt_size = PW'(4);
      chn_mask = 4'b1111;
      operation_start = 1'b1;
      @(negedge clk);
      operation_start = 1'b0;
      s_tvalid = '1;
      s_tlast = '0;
      m_tready = '1;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      checks++;
      if ({busy_a, error_a, cause_a} !== 5'b01_001 || {busy_b, error_b, cause_b} !== 5'b01_001 ||
          s_a.tready !== '0 || m_a.tvalid !== '0 || count_a !== '0)
         $display("FAIL abort: got be %b%b cause %b tready %b tvalid %b count %h want 01 cause 001 tready 0 count 0",
                  busy_a, error_a, cause_a, s_a.tready, m_a.tvalid, count_a);
      else passes++;
      @(negedge clk);
      pckt_size = PW'(1);
      operation_start = 1'b1;
      @(negedge clk);
      operation_start = 1'b0;
      #1;
      checks++;
      if (s_a.tready !== 4'b1111 || busy_a !== 1'b1 || cause_a !== 3'b000)
         $display("FAIL restart_from_error: got tready %b busy %b cause %b want 1111 1 000", s_a.tready, busy_a, cause_a);
      else passes++;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (count_a[0 +: CW] !== CW'(2) || count_a[3*CW +: CW] !== CW'(2))
         $display("FAIL count_before_reset: got %0d/%0d want 2/2", count_a[0 +: CW], count_a[3*CW +: CW]);
      else passes++;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({busy_a, complete_a, error_a, cause_a, done_a} !== 10'b0 || count_a !== '0 ||
          s_a.tready !== '0 || m_a.tvalid !== '0 || busy_b !== 1'b0 || count_b !== '0)
         $display("FAIL async_reset: got bce %b%b%b cause %b done %b count %h tready %b want all zero",
                  busy_a, complete_a, error_a, cause_a, done_a, count_a, s_a.tready);
      else passes++;
      s_tvalid = '0;
      m_tready = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      int p;
      logic [CH-1:0] mask;
      for (int k = 0; k < 3; k++) begin
         p = $urandom_range(1, 5);
         mask = CH'($urandom_range(1, 15));
         run_op(mask, p, p * $urandom_range(1, 4), p * $urandom_range(1, 4),
                p * $urandom_range(1, 4), p * $urandom_range(1, 4), 1'b1, "b2b");
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_mask();
      test_non_divisible();
      test_zero_size();
      test_abort_and_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
